// File: rtl/register_file_sb.sv
// Purpose: parametrised multi-port integer register file with per-register pending scoreboard.
// Latency: reads are combinational (0 cycles) with write-to-read bypass; writes/issues commit at the rising edge.
// Backpressure: none; rd_ready tells issue logic whether an operand is valid this cycle.
//
// Ports:
//   clk, rst                 clock and asynchronous active-high reset
//   rd_addr/rd_data/rd_ready NUM_READ packed read ports (port i at [i*AW +: AW] / [i*XLEN +: XLEN])
//   wr_en/wr_addr/wr_data    NUM_WRITE packed write ports, higher index wins on address collisions
//   iss_valid/iss_addr       marks a destination register pending when its producer issues
//   pend_cnt                 registered count of pending registers
module register_file_sb #(
    parameter int XLEN      = 32,
    parameter int NUM_REGS  = 32,
    parameter int NUM_READ  = 2,
    parameter int NUM_WRITE = 2,
    localparam int AW       = $clog2(NUM_REGS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_READ*AW-1:0]    rd_addr,
    output logic [NUM_READ*XLEN-1:0]  rd_data,
    output logic [NUM_READ-1:0]       rd_ready,
    input  logic [NUM_WRITE-1:0]      wr_en,
    input  logic [NUM_WRITE*AW-1:0]   wr_addr,
    input  logic [NUM_WRITE*XLEN-1:0] wr_data,
    input  logic                      iss_valid,
    input  logic [AW-1:0]             iss_addr,
    output logic [AW:0]               pend_cnt
);

    // Register 0 is hardwired to zero, so neither storage nor a pending bit exists for it.
    logic [XLEN-1:0]     regs     [1:NUM_REGS-1];
    logic [XLEN-1:0]     regs_nxt [1:NUM_REGS-1];
    logic [NUM_REGS-1:1] pend;
    logic [NUM_REGS-1:1] pend_nxt;
    logic [AW:0]         pend_cnt_nxt;

    // Next-state: ports are scanned in ascending order so the highest-index
    // matching port wins. The issue check comes last because a newly issued
    // producer supersedes one completing in the same cycle.
    always_comb begin
        regs_nxt     = regs;
        pend_nxt     = pend;
        pend_cnt_nxt = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            for (int w = 0; w < NUM_WRITE; w++) begin
                if (wr_en[w] && (wr_addr[w*AW +: AW] == AW'(r))) begin
                    regs_nxt[r] = wr_data[w*XLEN +: XLEN];
                    pend_nxt[r] = 1'b0;
                end
            end
            if (iss_valid && (iss_addr == AW'(r))) begin
                pend_nxt[r] = 1'b1;
            end
            pend_cnt_nxt = pend_cnt_nxt + (AW+1)'(pend_nxt[r]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 1; r < NUM_REGS; r++) begin
                regs[r] <= '0;
            end
            pend     <= '0;
            pend_cnt <= '0;
        end else begin
            for (int r = 1; r < NUM_REGS; r++) begin
                regs[r] <= regs_nxt[r];
            end
            pend     <= pend_nxt;
            pend_cnt <= pend_cnt_nxt;
        end
    end

    // Read ports. Bypass is suppressed while reset is held so the outputs show
    // the cleared state rather than a write that will never commit.
    always_comb begin
        rd_data  = '0;
        rd_ready = '1;
        for (int i = 0; i < NUM_READ; i++) begin
            if (rd_addr[i*AW +: AW] != '0) begin
                rd_data[i*XLEN +: XLEN] = regs[rd_addr[i*AW +: AW]];
                rd_ready[i]             = ~pend[rd_addr[i*AW +: AW]];
                if (!rst) begin
                    for (int w = 0; w < NUM_WRITE; w++) begin
                        if (wr_en[w] && (wr_addr[w*AW +: AW] == rd_addr[i*AW +: AW])) begin
                            rd_data[i*XLEN +: XLEN] = wr_data[w*XLEN +: XLEN];
                            rd_ready[i]             = 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule
